// File: rtl/band_energy_synth.sv
// Rebuilds the per-bin magnitude-squared spectrum from harmonic amplitudes A[1..L].
// Optional A^2 saturation and sticky sat_flag port: define BAND_ENERGY_SAT_EN.
module band_energy_synth #(
   parameter int          N        = 32,
   parameter int          Q        = 16,
   parameter logic [31:0] ONE_ON_R = 32'h00517CC1,
   parameter logic [9:0]  BIN_MAX  = 10'd256,
   parameter int          RD_LAT   = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         startbs,
   input  logic [31:0]  Wo,
   input  logic [9:0]   L,
   input  logic [31:0]  out_a,
   output logic [9:0]   addr_a,
   output logic [9:0]   addr_sw,
   output logic [31:0]  write_data_sw,
   output logic         wren_sw,
`ifdef BAND_ENERGY_SAT_EN
   output logic         sat_flag,
`endif
   output logic         donebs
);

   localparam logic [31:0] HALF     = 32'h0000_8000;
   localparam logic [31:0] NEG_HALF = 32'h8000_8000;

   typedef enum logic [3:0] {
      IDLE, INIT, EDGE_1, EDGE_2, EDGE_3, EDGE_4, EDGE_SET, RD_A,
      RD_WAIT, SQUARE, DIV, WR_SETUP, WR_BIN, NEXT_M, DONE
   } state_t;

   // Sign-magnitude 1-15-16 multiply: magnitude product truncated to Q16.
   function automatic logic [N-1:0] qmult(input logic [N-1:0] a, input logic [N-1:0] b);
      logic [2*N-3:0] prod;
      prod  = {{(N-1){1'b0}}, a[N-2:0]} * {{(N-1){1'b0}}, b[N-2:0]};
      qmult = {a[N-1] ^ b[N-1], prod[N-2+Q:Q]};
   endfunction

   function automatic logic [N-1:0] qadd(input logic [N-1:0] a, input logic [N-1:0] b);
      if (a[N-1] == b[N-1])
         qadd = {a[N-1], a[N-2:0] + b[N-2:0]};
      else if (a[N-2:0] >= b[N-2:0])
         qadd = {a[N-1], a[N-2:0] - b[N-2:0]};
      else
         qadd = {b[N-1], b[N-2:0] - a[N-2:0]};
   endfunction

   // Integer part must be clamped before narrowing, otherwise large edges would wrap.
   function automatic logic [9:0] clamp_bin(input logic [N-1:0] s);
      if (s[N-2:Q] > {5'd0, BIN_MAX})
         clamp_bin = BIN_MAX;
      else
         clamp_bin = s[Q+9:Q];
   endfunction

   state_t        state_q, state_d;
   logic [9:0]    m_q, m_d, i_q, i_d, am_q, am_d, bm_q, bm_d, cnt_q, cnt_d;
   logic [31:0]   lo_q, lo_d, hi_q, hi_d;
   logic [31:0]   quo_q, quo_d;
   logic [9:0]    rem_q, rem_d;
   logic [4:0]    step_q, step_d;
   logic [1:0]    wait_q, wait_d;
   logic [9:0]    addr_a_q, addr_a_d, addr_sw_q, addr_sw_d;
   logic [31:0]   wdata_q, wdata_d;
   logic          wren_q, wren_d, done_q, done_d, sat_q, sat_d;
   logic [10:0]   rem_shift;
   logic [31:0]   a2;

   always_comb begin
      state_d   = state_q;
      m_d       = m_q;
      i_d       = i_q;
      am_d      = am_q;
      bm_d      = bm_q;
      cnt_d     = cnt_q;
      lo_d      = lo_q;
      hi_d      = hi_q;
      quo_d     = quo_q;
      rem_d     = rem_q;
      step_d    = step_q;
      wait_d    = wait_q;
      addr_a_d  = addr_a_q;
      addr_sw_d = addr_sw_q;
      wdata_d   = wdata_q;
      wren_d    = 1'b0;
      done_d    = 1'b0;
      sat_d     = sat_q;
      rem_shift = {rem_q, quo_q[31]};
      a2        = qmult(out_a, out_a);
      a2[31]    = 1'b0;
`ifdef BAND_ENERGY_SAT_EN
      if (out_a[30:23] != 8'd0) a2 = 32'h7FFF_FFFF;
`endif
      case (state_q)
         IDLE: if (startbs) state_d = INIT;
         INIT: begin
            m_d     = 10'd1;
            sat_d   = 1'b0;
            state_d = (L == 10'd0) ? DONE : EDGE_1;
         end
         EDGE_1: begin
            lo_d    = qadd({6'b0, m_q, 16'b0}, NEG_HALF);
            hi_d    = qadd({6'b0, m_q, 16'b0}, HALF);
            state_d = EDGE_2;
         end
         EDGE_2: begin
            lo_d    = qmult(lo_q, Wo);
            hi_d    = qmult(hi_q, Wo);
            state_d = EDGE_3;
         end
         EDGE_3: begin
            lo_d    = qmult(lo_q, ONE_ON_R);
            hi_d    = qmult(hi_q, ONE_ON_R);
            state_d = EDGE_4;
         end
         EDGE_4: begin
            lo_d    = qadd(lo_q, HALF);
            hi_d    = qadd(hi_q, HALF);
            state_d = EDGE_SET;
         end
         EDGE_SET: begin
            am_d    = clamp_bin(lo_q);
            bm_d    = clamp_bin(hi_q);
            state_d = RD_A;
         end
         RD_A: begin
            addr_a_d = m_q;
            wait_d   = 2'd0;
            state_d  = RD_WAIT;
         end
         RD_WAIT: begin
            wait_d = wait_q + 2'd1;
            if (wait_q == 2'(RD_LAT - 1)) state_d = SQUARE;
         end
         SQUARE: begin
            quo_d  = a2;
            rem_d  = 10'd0;
            step_d = 5'd0;
            cnt_d  = bm_q - am_q;
`ifdef BAND_ENERGY_SAT_EN
            if (out_a[30:23] != 8'd0) sat_d = 1'b1;
`endif
            state_d = (bm_q <= am_q) ? NEXT_M : DIV;
         end
         DIV: begin
            // Restoring division: one quotient bit per cycle, MSB first.
            if (rem_shift >= {1'b0, cnt_q}) begin
               rem_d = 10'(rem_shift - {1'b0, cnt_q});
               quo_d = {quo_q[30:0], 1'b1};
            end else begin
               rem_d = rem_shift[9:0];
               quo_d = {quo_q[30:0], 1'b0};
            end
            step_d = step_q + 5'd1;
            if (step_q == 5'd31) state_d = WR_SETUP;
         end
         WR_SETUP: begin
            i_d     = am_q;
            state_d = WR_BIN;
         end
         WR_BIN: begin
            addr_sw_d = i_q;
            wdata_d   = quo_q;
            wren_d    = 1'b1;
            i_d       = i_q + 10'd1;
            if (i_q == bm_q - 10'd1) state_d = NEXT_M;
         end
         NEXT_M: begin
            m_d     = m_q + 10'd1;
            state_d = (({1'b0, m_q} + 11'd1) <= {1'b0, L}) ? EDGE_1 : DONE;
         end
         DONE: begin
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         m_q       <= '0;
         i_q       <= '0;
         am_q      <= '0;
         bm_q      <= '0;
         cnt_q     <= '0;
         lo_q      <= '0;
         hi_q      <= '0;
         quo_q     <= '0;
         rem_q     <= '0;
         step_q    <= '0;
         wait_q    <= '0;
         addr_a_q  <= '0;
         addr_sw_q <= '0;
         wdata_q   <= '0;
         wren_q    <= 1'b0;
         done_q    <= 1'b0;
         sat_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         m_q       <= m_d;
         i_q       <= i_d;
         am_q      <= am_d;
         bm_q      <= bm_d;
         cnt_q     <= cnt_d;
         lo_q      <= lo_d;
         hi_q      <= hi_d;
         quo_q     <= quo_d;
         rem_q     <= rem_d;
         step_q    <= step_d;
         wait_q    <= wait_d;
         addr_a_q  <= addr_a_d;
         addr_sw_q <= addr_sw_d;
         wdata_q   <= wdata_d;
         wren_q    <= wren_d;
         done_q    <= done_d;
         sat_q     <= sat_d;
      end
   end

   assign addr_a        = addr_a_q;
   assign addr_sw       = addr_sw_q;
   assign write_data_sw = wdata_q;
   assign wren_sw       = wren_q;
   assign donebs        = done_q;
`ifdef BAND_ENERGY_SAT_EN
   assign sat_flag      = sat_q;
`else
   logic unused_sat;
   assign unused_sat    = sat_q;
`endif

endmodule

// File: tb/tb_band_energy_synth.sv
// Directed bench for band_energy_synth with a two-cycle-latency model A RAM.
module tb_band_energy_synth;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        startbs = 1'b0;
   logic [31:0] Wo = '0;
   logic [9:0]  L = '0;
   logic [31:0] out_a = '0;
   logic [9:0]  addr_a, addr_sw;
   logic [31:0] write_data_sw;
   logic        wren_sw, donebs;
`ifdef BAND_ENERGY_SAT_EN
   logic        sat_flag;
`endif

   logic [31:0] mem [0:1023];
   logic [31:0] rd1 = '0;
   int checks = 0;
   int errors = 0;
   int done_cnt = 0;
   logic [9:0]  wr_addr [$];
   logic [31:0] wr_data [$];

   band_energy_synth dut (
      .clk(clk), .rst(rst), .startbs(startbs), .Wo(Wo), .L(L), .out_a(out_a),
      .addr_a(addr_a), .addr_sw(addr_sw), .write_data_sw(write_data_sw),
      .wren_sw(wren_sw),
`ifdef BAND_ENERGY_SAT_EN
      .sat_flag(sat_flag),
`endif
      .donebs(donebs)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      rd1   <= mem[addr_a];
      out_a <= rd1;
   end

   always @(negedge clk) begin
      if (wren_sw) begin
         wr_addr.push_back(addr_sw);
         wr_data.push_back(write_data_sw);
      end
      if (donebs) done_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end else
         $display("ok   %s: %h", tag, got);
   endtask

   task automatic clear_log();
      wr_addr.delete();
      wr_data.delete();
      done_cnt = 0;
   endtask

   task automatic run_op(input logic [9:0] l, input logic [31:0] wo, output int lat);
      clear_log();
      @(negedge clk);
      Wo = wo; L = l; startbs = 1'b1;
      @(negedge clk);
      startbs = 1'b0;
      lat = 0;
      while (!donebs && lat < 5000) begin
         @(negedge clk);
         lat++;
      end
      check("done_seen", {31'd0, donebs}, 32'd1);
      repeat (3) @(negedge clk);
   endtask

   task automatic check_single_band(input string tag, input logic [31:0] data);
      check({tag, "_nwr"}, wr_addr.size(), 32'd8);
      for (int k = 0; k < wr_addr.size() && k < 8; k++) begin
         check({tag, "_addr"}, {22'd0, wr_addr[k]}, 32'(4 + k));
         check({tag, "_data"}, wr_data[k], data);
      end
      check({tag, "_done1"}, done_cnt, 32'd1);
   endtask

   initial begin
      int lat;
      logic [31:0] exp;
      logic [9:0]  maxa;
      for (int k = 0; k < 1024; k++) mem[k] = '0;
      repeat (2) @(negedge clk);
      check("rst_addr_a", {22'd0, addr_a}, 32'd0);
      check("rst_addr_sw", {22'd0, addr_sw}, 32'd0);
      check("rst_wdata", write_data_sw, 32'd0);
      check("rst_wren", {31'd0, wren_sw}, 32'd0);
      check("rst_done", {31'd0, donebs}, 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // One band: A=2.0 -> 4.0 spread over bins 4..11
      mem[1] = 32'h0002_0000;
      run_op(10'd1, 32'h0000_1922, lat);
      check_single_band("t1", 32'h0000_8000);
`ifdef BAND_ENERGY_SAT_EN
      check("t1_sat", {31'd0, sat_flag}, 32'd0);
`endif

      // Three bands
      mem[1] = 32'h0001_0000; mem[2] = 32'h0002_0000; mem[3] = 32'h0000_8000;
      run_op(10'd3, 32'h0000_1922, lat);
      check("t2_nwr", wr_addr.size(), 32'd24);
      for (int k = 0; k < wr_addr.size() && k < 24; k++) begin
         exp = (k < 8) ? 32'h0000_2000 : (k < 16) ? 32'h0000_8000 : 32'h0000_0800;
         check("t2_addr", {22'd0, wr_addr[k]}, 32'(4 + k));
         check("t2_data", wr_data[k], exp);
      end
      check("t2_done1", done_cnt, 32'd1);

      // L=0: no writes, done two cycles after start is sampled
      run_op(10'd0, 32'h0000_1922, lat);
      check("t3_lat", lat, 32'd2);
      check("t3_nwr", wr_addr.size(), 32'd0);
      check("t3_done1", done_cnt, 32'd1);

      // Wo=pi/2: band 1 bins 64..191, band 2 192..319 clamped to 255
      mem[1] = 32'h0001_0000; mem[2] = 32'h0008_0000;
      run_op(10'd2, 32'h0001_9220, lat);
      check("t4_nwr", wr_addr.size(), 32'd192);
      maxa = '0;
      for (int k = 0; k < wr_addr.size(); k++) begin
         if (wr_addr[k] > maxa) maxa = wr_addr[k];
         if (k == 0 || k == 127 || k == 128 || k == 191) begin
            check("t4_addr", {22'd0, wr_addr[k]}, 32'(64 + k));
            check("t4_data", wr_data[k], (k < 128) ? 32'h0000_0200 : 32'h0001_0000);
         end
      end
      check("t4_maxaddr", {22'd0, maxa}, 32'd255);

      // Reset during DIV of m=2 aborts
      mem[1] = 32'h0001_0000; mem[2] = 32'h0002_0000; mem[3] = 32'h0000_8000;
      clear_log();
      @(negedge clk);
      Wo = 32'h0000_1922; L = 10'd3; startbs = 1'b1;
      @(negedge clk);
      startbs = 1'b0;
      lat = 0;
      while (addr_a != 10'd2 && lat < 2000) begin
         @(negedge clk);
         lat++;
      end
      check("t5_reach_m2", {22'd0, addr_a}, 32'd2);
      repeat (12) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("t5_rst_addr_sw", {22'd0, addr_sw}, 32'd0);
      rst = 1'b0;
      clear_log();
      repeat (80) @(negedge clk);
      check("t5_nwr", wr_addr.size(), 32'd0);
      check("t5_done0", done_cnt, 32'd0);
      check("t5_addr_a", {22'd0, addr_a}, 32'd0);
      check("t5_wdata", write_data_sw, 32'd0);

      mem[1] = 32'h0002_0000;
      run_op(10'd1, 32'h0000_1922, lat);
      check_single_band("t5_rerun", 32'h0000_8000);

      // |A| = 256.0: A^2 overflows Q16.16
      mem[1] = 32'h0100_0000;
      run_op(10'd1, 32'h0000_1922, lat);
`ifdef BAND_ENERGY_SAT_EN
      check_single_band("t6_sat", 32'h0FFF_FFFF);
      check("t6_flag", {31'd0, sat_flag}, 32'd1);
`else
      check_single_band("t6_wrap", 32'h0000_0000);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
